// File: rtl/spi_v3_components_packet_serializer.sv
// spi_v3_components_packet_serializer: splits a wide packet into narrow val/rdy chunks with selectable order and length.
// Optional send_last output enabled by defining SPI_V3_SERIALIZER_LAST_EN.
module spi_v3_components_packet_serializer #(
    parameter int nbits_in = 32,
    parameter int nbits_out = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int num_chunks = (nbits_in + nbits_out - 1) / nbits_out,
    localparam int len_bits = $clog2(num_chunks + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [nbits_in-1:0]  recv_msg,
    input  logic [len_bits-1:0]  recv_len,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [nbits_out-1:0] send_msg,
    output logic                 busy
`ifdef SPI_V3_SERIALIZER_LAST_EN
    ,
    output logic                 send_last
`endif
);
    localparam int data_w = num_chunks * nbits_out;
    localparam logic [len_bits-1:0] full_len = len_bits'(num_chunks);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_n;
    logic [data_w-1:0]   data, data_n;
    logic [len_bits-1:0] cnt, cnt_n, len, len_n, eff_len, idx;
    logic                last, accept;

    assign busy     = state == SEND;
    assign send_val = busy;
    assign last     = cnt == len - 1'b1;
    assign recv_rdy = ~busy | (last & send_rdy);
    assign accept   = recv_val & recv_rdy;
    assign eff_len  = (recv_len == '0 || recv_len > full_len) ? full_len : recv_len;
    assign idx      = MSB_FIRST ? len - 1'b1 - cnt : cnt;
    // Output comes only from registered state so no recv_* path reaches send_msg.
    assign send_msg = busy ? data[nbits_out*int'(idx) +: nbits_out] : '0;
`ifdef SPI_V3_SERIALIZER_LAST_EN
    assign send_last = busy & last;
`endif

    always_comb begin
        state_n = state;
        data_n  = data;
        cnt_n   = cnt;
        len_n   = len;
        if (accept) begin
            state_n = SEND;
            data_n  = data_w'(recv_msg);
            cnt_n   = '0;
            len_n   = eff_len;
        end else if (busy & send_rdy) begin
            state_n = last ? IDLE : SEND;
            cnt_n   = last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            len   <= full_len;
        end else begin
            state <= state_n;
            data  <= data_n;
            cnt   <= cnt_n;
            len   <= len_n;
        end
    end
endmodule

// File: tb/tb_spi_v3_components_packet_serializer.sv
// tb_spi_v3_components_packet_serializer: four serializer configurations checked against a chunk-queue model.
module tb_spi_v3_components_packet_serializer;
    localparam int NIN [4] = '{32, 32, 12, 8};
    localparam bit MSB [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        recv_val [4];
    logic        recv_rdy [4];
    logic [31:0] recv_msg [4];
    logic [2:0]  recv_len [4];
    logic        send_val [4];
    logic        send_rdy [4];
    logic [7:0]  send_msg [4];
    logic        busy [4];
    logic        send_last [4];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mbuf [4][16];
    int          mhead [4];
    int          mtail [4];

    always #5 clk = ~clk;

    spi_v3_components_packet_serializer #(.nbits_in(32), .nbits_out(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]), .recv_msg(recv_msg[0]),
        .recv_len(recv_len[0]), .send_val(send_val[0]), .send_rdy(send_rdy[0]), .send_msg(send_msg[0]), .busy(busy[0])
`ifdef SPI_V3_SERIALIZER_LAST_EN
        , .send_last(send_last[0])
`endif
    );
    spi_v3_components_packet_serializer #(.nbits_in(32), .nbits_out(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]), .recv_msg(recv_msg[1]),
        .recv_len(recv_len[1]), .send_val(send_val[1]), .send_rdy(send_rdy[1]), .send_msg(send_msg[1]), .busy(busy[1])
`ifdef SPI_V3_SERIALIZER_LAST_EN
        , .send_last(send_last[1])
`endif
    );
    spi_v3_components_packet_serializer #(.nbits_in(12), .nbits_out(8), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .reset(reset), .recv_val(recv_val[2]), .recv_rdy(recv_rdy[2]), .recv_msg(recv_msg[2][11:0]),
        .recv_len(recv_len[2][1:0]), .send_val(send_val[2]), .send_rdy(send_rdy[2]), .send_msg(send_msg[2]), .busy(busy[2])
`ifdef SPI_V3_SERIALIZER_LAST_EN
        , .send_last(send_last[2])
`endif
    );
    spi_v3_components_packet_serializer #(.nbits_in(8), .nbits_out(8), .MSB_FIRST(1'b1)) u3 (
        .clk(clk), .reset(reset), .recv_val(recv_val[3]), .recv_rdy(recv_rdy[3]), .recv_msg(recv_msg[3][7:0]),
        .recv_len(recv_len[3][0:0]), .send_val(send_val[3]), .send_rdy(send_rdy[3]), .send_msg(send_msg[3]), .busy(busy[3])
`ifdef SPI_V3_SERIALIZER_LAST_EN
        , .send_last(send_last[3])
`endif
    );

    // Model: each accepted packet becomes a list of chunks in send order; the head is what must be on send_msg.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                mhead[i] = 0;
                mtail[i] = 0;
            end else begin
                int n, nc, lb, l, k;
                logic [63:0] m;
                logic rdy;
                n = mtail[i] - mhead[i];
                rdy = (n == 0) || (n == 1 && send_rdy[i]);
                if (n > 0 && send_rdy[i]) mhead[i]++;
                if (recv_val[i] && rdy) begin
                    nc = (NIN[i] + 7) / 8;
                    lb = 0;
                    while ((1 << lb) <= nc) lb++;
                    l = int'(recv_len[i]) & ((1 << lb) - 1);
                    if (l == 0 || l > nc) l = nc;
                    m = {32'd0, recv_msg[i]} & ((64'd1 << NIN[i]) - 64'd1);
                    for (int j = 0; j < l; j++) begin
                        k = MSB[i] ? l - 1 - j : j;
                        mbuf[i][mtail[i] % 16] = m[8*k +: 8];
                        mtail[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int n;
            logic [7:0] em;
            n = mtail[i] - mhead[i];
            em = (n > 0) ? mbuf[i][mhead[i] % 16] : 8'h00;
            checks++;
            if (send_val[i] !== (n > 0) || busy[i] !== (n > 0) || send_msg[i] !== em ||
                recv_rdy[i] !== ((n == 0) || (n == 1 && send_rdy[i]))) begin
                errors++;
                $display("FAIL model dut%0d t=%0t: val=%b busy=%b msg=%h rdy=%b, expected val=%b msg=%h rdy=%b",
                         i, $time, send_val[i], busy[i], send_msg[i], recv_rdy[i], n > 0, em,
                         (n == 0) || (n == 1 && send_rdy[i]));
            end
`ifdef SPI_V3_SERIALIZER_LAST_EN
            checks++;
            if (send_last[i] !== (n == 1)) begin
                errors++;
                $display("FAIL last dut%0d t=%0t: got %b expected %b", i, $time, send_last[i], n == 1);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input int d, input logic [31:0] seq, input int n, input string name);
        for (int j = 0; j < n; j++) begin
            chk(name, {24'd0, send_msg[d]}, {24'd0, seq[8*(n-1-j) +: 8]});
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            recv_val[i] = 1'b0;
            recv_msg[i] = '0;
            recv_len[i] = '0;
            send_rdy[i] = 1'b1;
        end
        #1;
        chk("reset send_val", {31'd0, send_val[0]}, 32'd0);
        chk("reset recv_rdy", {31'd0, recv_rdy[0]}, 32'd1);
        chk("reset send_msg", {24'd0, send_msg[0]}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        // MSB-first and LSB-first full packets in parallel
        recv_val[0] = 1'b1; recv_msg[0] = 32'hAABBCCDD;
        recv_val[1] = 1'b1; recv_msg[1] = 32'hAABBCCDD;
        tick();
        recv_val[0] = 1'b0; recv_val[1] = 1'b0;
        chk("lsb first", {24'd0, send_msg[1]}, 32'hDD);
        expect_seq(0, 32'hAABBCCDD, 4, "msb order");
        chk("idle rdy", {31'd0, recv_rdy[0]}, 32'd1);
        chk("idle val", {31'd0, send_val[0]}, 32'd0);
        // short length, 12-bit zero extension, 8-bit pass-through back-to-back
        recv_val[0] = 1'b1; recv_msg[0] = 32'hAABBCCDD; recv_len[0] = 3'd2;
        recv_val[2] = 1'b1; recv_msg[2] = 32'h00000ABC;
        recv_val[3] = 1'b1; recv_msg[3] = 32'h0000005A;
        tick();
        recv_val[0] = 1'b0; recv_val[2] = 1'b0; recv_len[0] = 3'd0;
        recv_msg[3] = 32'h000000C3;
        chk("len2 first", {24'd0, send_msg[0]}, 32'hCC);
        chk("12b top", {24'd0, send_msg[2]}, 32'h0A);
        chk("8b first", {24'd0, send_msg[3]}, 32'h5A);
        chk("8b rdy", {31'd0, recv_rdy[3]}, 32'd1);
        tick();
        recv_val[3] = 1'b0;
        chk("len2 second", {24'd0, send_msg[0]}, 32'hDD);
        chk("12b low", {24'd0, send_msg[2]}, 32'hBC);
        chk("8b second", {24'd0, send_msg[3]}, 32'hC3);
        tick();
        chk("len2 idle", {31'd0, send_val[0]}, 32'd0);
        // backpressure after the second chunk, oversize length treated as full
        recv_val[0] = 1'b1; recv_len[0] = 3'd5;
        tick();
        recv_val[0] = 1'b0; recv_len[0] = 3'd0;
        chk("bp AA", {24'd0, send_msg[0]}, 32'hAA);
        tick();
        send_rdy[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("bp hold", {24'd0, send_msg[0]}, 32'hBB);
            chk("bp val", {31'd0, send_val[0]}, 32'd1);
            chk("bp rdy", {31'd0, recv_rdy[0]}, 32'd0);
        end
        send_rdy[0] = 1'b1;
        #1;
        tick();
        expect_seq(0, 32'h0000CCDD, 2, "bp tail");
        // back-to-back with recv_val held high
        recv_val[0] = 1'b1; recv_msg[0] = 32'h11223344;
        tick();
        recv_msg[0] = 32'h55667788;
        expect_seq(0, 32'h112233, 3, "b2b first");
        chk("b2b 44", {24'd0, send_msg[0]}, 32'h44);
        chk("b2b rdy", {31'd0, recv_rdy[0]}, 32'd1);
        tick();
        recv_val[0] = 1'b0;
        expect_seq(0, 32'h55667788, 4, "b2b second");
        chk("b2b idle", {31'd0, send_val[0]}, 32'd0);
        // asynchronous reset mid-packet
        recv_val[0] = 1'b1; recv_msg[0] = 32'hAABBCCDD;
        tick();
        recv_val[0] = 1'b0;
        chk("pre-reset AA", {24'd0, send_msg[0]}, 32'hAA);
        reset = 1'b1;
        #1;
        chk("async val", {31'd0, send_val[0]}, 32'd0);
        chk("async msg", {24'd0, send_msg[0]}, 32'd0);
        chk("async rdy", {31'd0, recv_rdy[0]}, 32'd1);
        tick();
        reset = 1'b0;
        tick();
        recv_val[0] = 1'b1; recv_msg[0] = 32'h01020304;
        tick();
        recv_val[0] = 1'b0;
`ifdef SPI_V3_SERIALIZER_LAST_EN
        chk("last low", {31'd0, send_last[0]}, 32'd0);
`endif
        expect_seq(0, 32'h010203, 3, "post-reset");
        chk("post-reset 04", {24'd0, send_msg[0]}, 32'h04);
`ifdef SPI_V3_SERIALIZER_LAST_EN
        chk("last high", {31'd0, send_last[0]}, 32'd1);
`endif
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
